// File: rtl/riscv_dual_mem_model_pkg.sv
// Shared definitions for the dual-port RISC-V memory model.
//   - mem_state_e : per-port handshake state (idle / waiting / responding)
//   - MEM_CNT_W   : wait-state counter width (supports 0..15 wait cycles)
//   - be_merge()  : byte-lane merge of store data into an existing word
// be_merge() works on a fixed maximum width so that any data width up to
// MEM_MAX_DW bits can use it through zero-extension and truncation.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    localparam int MEM_CNT_W  = 4;
    localparam int MEM_MAX_DW = 128;
    localparam int MEM_MAX_BE = MEM_MAX_DW / 8;

    // Byte lane i of the result comes from new_w when be[i] is set, else from old_w.
    function automatic logic [MEM_MAX_DW-1:0] be_merge(
        input logic [MEM_MAX_DW-1:0] old_w,
        input logic [MEM_MAX_DW-1:0] new_w,
        input logic [MEM_MAX_BE-1:0] be
    );
        logic [MEM_MAX_DW-1:0] res;
        res = old_w;
        for (int i = 0; i < MEM_MAX_BE; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/riscv_dual_mem_model_if.sv
// Bus interface between a RISC-V core (master) and the memory model (slave).
//   Fetch port   : imem_req/imem_addr -> imem_gnt/imem_rvalid/imem_rdata
//   Program load : prog_we/prog_addr/prog_wdata (side-band imem fill)
//   Data port    : dmem_req/we/be/addr/wdata -> dmem_gnt/rvalid/rdata/err
interface riscv_dual_mem_model_if #(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_IMEM_ADDR_WIDTH = 9,
    parameter int P_DMEM_ADDR_WIDTH = 8
);
    logic                           imem_req;
    logic [P_IMEM_ADDR_WIDTH-1:0]   imem_addr;
    logic                           imem_gnt;
    logic                           imem_rvalid;
    logic [P_DATA_WIDTH-1:0]        imem_rdata;

    logic                           prog_we;
    logic [P_IMEM_ADDR_WIDTH-1:0]   prog_addr;
    logic [P_DATA_WIDTH-1:0]        prog_wdata;

    logic                           dmem_req;
    logic                           dmem_we;
    logic [P_DATA_WIDTH/8-1:0]      dmem_be;
    logic [P_DMEM_ADDR_WIDTH-1:0]   dmem_addr;
    logic [P_DATA_WIDTH-1:0]        dmem_wdata;
    logic                           dmem_gnt;
    logic                           dmem_rvalid;
    logic [P_DATA_WIDTH-1:0]        dmem_rdata;
    logic                           dmem_err;

    modport master (
        output imem_req, imem_addr,
        output prog_we, prog_addr, prog_wdata,
        output dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
    );

    modport slave (
        input  imem_req, imem_addr,
        input  prog_we, prog_addr, prog_wdata,
        input  dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata,
        output imem_gnt, imem_rvalid, imem_rdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata, dmem_err
    );

endinterface

// File: rtl/riscv_dual_mem_model_port_fsm.sv
// Request/grant/response handshake controller for one memory port.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : request from the core
//   gnt_o         : port can accept a request this cycle (IDLE or RESP)
//   accept_o      : req_i & gnt_o, the array-side capture strobe
//   rvalid_o      : one-cycle response pulse, P_WAIT+1 cycles after acceptance
module mem_port_fsm
    import riscv_mem_pkg::*;
#(
    parameter int P_WAIT = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    output logic gnt_o,
    output logic accept_o,
    output logic rvalid_o
);

    localparam logic [MEM_CNT_W-1:0] WAIT_LOAD = MEM_CNT_W'(P_WAIT);
    localparam logic [MEM_CNT_W-1:0] CNT_ONE   = MEM_CNT_W'(1);
    localparam logic [MEM_CNT_W-1:0] CNT_ZERO  = MEM_CNT_W'(0);
    localparam bit                   HAS_WAIT  = (P_WAIT > 0);

    mem_state_e           state_q;
    logic [MEM_CNT_W-1:0] cnt_q;
    logic                 gnt_q;
    logic                 rvalid_q;

    assign accept_o = req_i & gnt_q;
    assign gnt_o    = gnt_q;
    assign rvalid_o = rvalid_q;

    // State, wait counter and registered gnt/rvalid; gnt/rvalid are computed
    // from the state being entered so they line up with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= MEM_IDLE;
            cnt_q    <= CNT_ZERO;
            gnt_q    <= 1'b1;
            rvalid_q <= 1'b0;
        end else begin
            case (state_q)
                MEM_IDLE, MEM_RESP: begin
                    if (accept_o) begin
                        cnt_q <= WAIT_LOAD;
                        if (HAS_WAIT) begin
                            state_q  <= MEM_WAIT;
                            gnt_q    <= 1'b0;
                            rvalid_q <= 1'b0;
                        end else begin
                            state_q  <= MEM_RESP;
                            gnt_q    <= 1'b1;
                            rvalid_q <= 1'b1;
                        end
                    end else begin
                        state_q  <= MEM_IDLE;
                        cnt_q    <= CNT_ZERO;
                        gnt_q    <= 1'b1;
                        rvalid_q <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    // Leave on the cycle the counter shows 1; <= also recovers
                    // from a counter that is unexpectedly zero.
                    if (cnt_q <= CNT_ONE) begin
                        state_q  <= MEM_RESP;
                        cnt_q    <= CNT_ZERO;
                        gnt_q    <= 1'b1;
                        rvalid_q <= 1'b1;
                    end else begin
                        state_q  <= MEM_WAIT;
                        cnt_q    <= cnt_q - CNT_ONE;
                        gnt_q    <= 1'b0;
                        rvalid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= MEM_IDLE;
                    cnt_q    <= CNT_ZERO;
                    gnt_q    <= 1'b1;
                    rvalid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_dual_mem_model.sv
// Instruction/data memory model for a RISC-V core.
//   clk_i  : clock, all state on the rising edge
//   rst_ni : asynchronous active-low reset (memory arrays are not reset)
//   bus_if : slave side of riscv_dual_mem_model_if (fetch, program-load, data)
// Each port has its own mem_port_fsm; the arrays and the response data
// registers live here. Reads are captured at the accepting edge, so a write
// on that same edge is seen only by later accesses.
module riscv_dual_mem_model
    import riscv_mem_pkg::*;
#(
    parameter int P_DATA_WIDTH      = 32,
    parameter int P_IMEM_ADDR_WIDTH = 9,
    parameter int P_DMEM_ADDR_WIDTH = 8,
    parameter int P_IMEM_WAIT       = 0,
    parameter int P_DMEM_WAIT       = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    riscv_dual_mem_model_if.slave  bus_if
);

    localparam int BE_W = P_DATA_WIDTH / 8;

    logic [P_DATA_WIDTH-1:0] imem_mem_q [2**P_IMEM_ADDR_WIDTH];
    logic [P_DATA_WIDTH-1:0] dmem_mem_q [2**P_DMEM_ADDR_WIDTH];

    logic                    imem_accept_s;
    logic                    imem_gnt_s;
    logic                    imem_rvalid_s;
    logic [P_DATA_WIDTH-1:0] imem_rdata_d;
    logic [P_DATA_WIDTH-1:0] imem_rdata_q;

    logic                    dmem_accept_s;
    logic                    dmem_gnt_s;
    logic                    dmem_rvalid_s;
    logic                    dmem_be_none_s;
    logic                    dmem_commit_s;
    logic [MEM_MAX_DW-1:0]   dmem_merged_s;
    logic [P_DATA_WIDTH-1:0] dmem_rdata_d;
    logic [P_DATA_WIDTH-1:0] dmem_rdata_q;
    logic                    dmem_err_d;
    logic                    dmem_err_q;

    mem_port_fsm #(.P_WAIT(P_IMEM_WAIT)) u_imem_fsm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (bus_if.imem_req),
        .gnt_o    (imem_gnt_s),
        .accept_o (imem_accept_s),
        .rvalid_o (imem_rvalid_s)
    );

    mem_port_fsm #(.P_WAIT(P_DMEM_WAIT)) u_dmem_fsm (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (bus_if.dmem_req),
        .gnt_o    (dmem_gnt_s),
        .accept_o (dmem_accept_s),
        .rvalid_o (dmem_rvalid_s)
    );

    assign dmem_be_none_s = (bus_if.dmem_be == {BE_W{1'b0}});
    assign dmem_commit_s  = dmem_accept_s & bus_if.dmem_we & ~dmem_be_none_s;
    assign dmem_merged_s  = be_merge(MEM_MAX_DW'(dmem_mem_q[bus_if.dmem_addr]),
                                     MEM_MAX_DW'(bus_if.dmem_wdata),
                                     MEM_MAX_BE'(bus_if.dmem_be));

    // Program-load writes are independent of the fetch handshake.
    always_ff @(posedge clk_i) begin
        if (bus_if.prog_we) begin
            imem_mem_q[bus_if.prog_addr] <= bus_if.prog_wdata;
        end
    end

    // Stores commit at the accepting edge, only in enabled byte lanes.
    always_ff @(posedge clk_i) begin
        if (dmem_commit_s) begin
            dmem_mem_q[bus_if.dmem_addr] <= P_DATA_WIDTH'(dmem_merged_s);
        end
    end

    // Fetch response data: captured on acceptance, held through WAIT/RESP.
    always_comb begin
        imem_rdata_d = imem_rdata_q;
        if (imem_accept_s) begin
            imem_rdata_d = imem_mem_q[bus_if.imem_addr];
        end else begin
            imem_rdata_d = imem_rdata_q;
        end
    end

    // Data response: loads return the word, stores return zero and flag an
    // empty byte-enable as an error.
    always_comb begin
        dmem_rdata_d = dmem_rdata_q;
        dmem_err_d   = dmem_err_q;
        if (dmem_accept_s) begin
            if (bus_if.dmem_we) begin
                dmem_rdata_d = {P_DATA_WIDTH{1'b0}};
                dmem_err_d   = dmem_be_none_s;
            end else begin
                dmem_rdata_d = dmem_mem_q[bus_if.dmem_addr];
                dmem_err_d   = 1'b0;
            end
        end else begin
            dmem_rdata_d = dmem_rdata_q;
            dmem_err_d   = dmem_err_q;
        end
    end

    // Response data registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imem_rdata_q <= {P_DATA_WIDTH{1'b0}};
            dmem_rdata_q <= {P_DATA_WIDTH{1'b0}};
            dmem_err_q   <= 1'b0;
        end else begin
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            dmem_err_q   <= dmem_err_d;
        end
    end

    assign bus_if.imem_gnt    = imem_gnt_s;
    assign bus_if.imem_rvalid = imem_rvalid_s;
    assign bus_if.imem_rdata  = imem_rdata_q;
    assign bus_if.dmem_gnt    = dmem_gnt_s;
    assign bus_if.dmem_rvalid = dmem_rvalid_s;
    assign bus_if.dmem_rdata  = dmem_rdata_q;
    // err only qualifies a response; it is held low between responses.
    assign bus_if.dmem_err    = dmem_err_q & dmem_rvalid_s;

endmodule
